// File: rtl/stage_id_pkg.sv
// stage_id_pkg: shared control layout, instruction modes and decode helpers for the ID stage
package stage_id_pkg;
  localparam int CTRL_W = 9;
  localparam int CTRL_S = 0;
  localparam int CTRL_BR = 1;
  localparam int CTRL_WB = 2;
  localparam int CTRL_MW = 3;
  localparam int CTRL_MR = 4;
  localparam int CTRL_ALU = 5;
  localparam int PC_REG_DEF = 15;
  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10
  } mode_e;
  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s;
  } ctrl_t;
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return c;
      4'h3: return ~c;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return c & ~z;
      4'h9: return ~c | z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return ~z & (n == v);
      4'hd: return z | (n != v);
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic ctrl_t control_unit(input logic [1:0] mode, input logic [3:0] op, input logic s);
    ctrl_t c;
    c = '0;
    case (mode_e'(mode))
      MODE_DP: begin
        c.s = s;
        case (op)
          4'b1101: {c.alu_cmd, c.wb_en} = 5'b0001_1;
          4'b1111: {c.alu_cmd, c.wb_en} = 5'b1001_1;
          4'b0100: {c.alu_cmd, c.wb_en} = 5'b0010_1;
          4'b0101: {c.alu_cmd, c.wb_en} = 5'b0011_1;
          4'b0010: {c.alu_cmd, c.wb_en} = 5'b0100_1;
          4'b0110: {c.alu_cmd, c.wb_en} = 5'b0101_1;
          4'b0000: {c.alu_cmd, c.wb_en} = 5'b0110_1;
          4'b1100: {c.alu_cmd, c.wb_en} = 5'b0111_1;
          4'b0001: {c.alu_cmd, c.wb_en} = 5'b1000_1;
          4'b1010: {c.alu_cmd, c.wb_en} = 5'b0100_0;
          4'b1000: {c.alu_cmd, c.wb_en} = 5'b0110_0;
          default: {c.alu_cmd, c.wb_en} = 5'b0000_0;
        endcase
      end
      MODE_MEM: begin
        c.alu_cmd = 4'b0010;
        c.mem_read = s;
        c.mem_write = ~s;
        c.wb_en = s;
      end
      MODE_BR: c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register count of in-flight writes with issue, write-back and flush-undo ports
module reg_scoreboard
  import stage_id_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int SB_CNT_W = 2,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_idx,
  input  logic             dec_en,
  input  logic [REG_W-1:0] dec_idx,
  input  logic             undo_en,
  input  logic [REG_W-1:0] undo_idx,
  output logic [NREGS-1:0] pending,
  output logic [NREGS-1:0] single,
  output logic [NREGS-1:0] sat
);
  logic [SB_CNT_W-1:0] cnt [NREGS];
  logic [SB_CNT_W-1:0] cnt_nx [NREGS];
  logic [SB_CNT_W:0] sum [NREGS];
  logic [1:0] dn [NREGS];
  logic [NREGS-1:0] up, under;
  // net each register's increment against up to two decrements, flooring at zero
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      up[r] = inc_en && inc_idx == REG_W'(r);
      dn[r] = 2'(dec_en && dec_idx == REG_W'(r)) + 2'(undo_en && undo_idx == REG_W'(r));
      sum[r] = {1'b0, cnt[r]} + (SB_CNT_W+1)'(up[r]);
      under[r] = sum[r] < (SB_CNT_W+1)'(dn[r]);
      cnt_nx[r] = under[r] ? '0 : SB_CNT_W'(sum[r] - (SB_CNT_W+1)'(dn[r]));
      pending[r] = cnt[r] != '0;
      single[r] = cnt[r] == SB_CNT_W'(1);
      sat[r] = &cnt[r];
    end
  end
  // counter state; a write-back to a register with nothing outstanding is a protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nx[r];
      a_no_underflow: assert (under == '0);
    end
  end
endmodule

// File: rtl/stage_id_sb.sv
// stage_id_sb: decode stage with scoreboard hazard stall, write-back bypass and ID/EX handshake register
module stage_id_sb
  import stage_id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS = 16,
  parameter int SB_CNT_W = 2,
  parameter int PC_REG = PC_REG_DEF,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       inst,
  input  logic [3:0]        status,
  input  logic              flush,
  input  logic              wb_wr_en,
  input  logic [REG_W-1:0]  wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic              imm_out,
  output logic [11:0]       shift_op_out,
  output logic [23:0]       imm24_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
  output logic              sb_stall
);
  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);
  ctrl_t dec, ctrl;
  logic two_src, hazard, fire;
  logic [REG_W-1:0] src1, src2, dest;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0] pending, single, sat, wb_hit, busy;
  assign dec = control_unit(inst[27:26], inst[24:21], inst[20]);
  assign ctrl = cond_check(inst[31:28], status) ? dec : '0;
  assign src1 = REG_W'(inst[19:16]);
  assign dest = REG_W'(inst[15:12]);
  assign src2 = dec.mem_write ? dest : REG_W'(inst[3:0]);
  assign two_src = ~inst[25] | dec.mem_write;
  assign rd1 = (src1 == PC_IDX) ? pc_in : (wb_wr_en && wb_dest == src1) ? wb_value : regs[src1];
  assign rd2 = (src2 == PC_IDX) ? pc_in : (wb_wr_en && wb_dest == src2) ? wb_value : regs[src2];
  assign wb_hit = wb_wr_en ? NREGS'(1) << wb_dest : '0;
  assign busy = pending & ~(single & wb_hit);
  assign hazard = (~dec.branch & busy[src1]) | (two_src & busy[src2]) |
                  (ctrl.wb_en & (dest != PC_IDX) & sat[dest]);
  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
  assign fire = in_valid & in_ready;
  assign sb_stall = in_valid & hazard;
  reg_scoreboard #(.NREGS(NREGS), .SB_CNT_W(SB_CNT_W), .REG_W(REG_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .inc_en(fire & ctrl.wb_en & (dest != PC_IDX)),
    .inc_idx(dest),
    .dec_en(wb_wr_en & (wb_dest != PC_IDX)),
    .dec_idx(wb_dest),
    .undo_en(flush & out_valid & ctrl_out[CTRL_WB] & (dest_out != PC_IDX)),
    .undo_idx(dest_out),
    .pending(pending),
    .single(single),
    .sat(sat)
  );
  // register file; the PC index is read-only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_wr_en && wb_dest != PC_IDX) begin
      regs[wb_dest] <= wb_value;
    end
  end
  // ID/EX register: flush kills, fire loads, consumption empties, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ctrl_out <= '0;
      pc_out <= '0;
      reg1_out <= '0;
      reg2_out <= '0;
      imm_out <= 1'b0;
      shift_op_out <= '0;
      imm24_out <= '0;
      dest_out <= '0;
      src1_out <= '0;
      src2_out <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      ctrl_out <= ctrl;
      pc_out <= pc_in;
      reg1_out <= rd1;
      reg2_out <= rd2;
      imm_out <= inst[25];
      shift_op_out <= inst[11:0];
      imm24_out <= inst[23:0];
      dest_out <= dest;
      src1_out <= src1;
      src2_out <= src2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
